stopwatch_ctrl_fsm: RTL and testbench



---
 rtl/stopwatch_ctrl_fsm.sv | 112 +++++++++++
 tb/tb_stopwatch_ctrl_fsm.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl_fsm.sv
// Button-driven stopwatch controller: run/stop toggling, long-press clear from STOP,
// and a LAP mode that freezes the display while counting continues.
module stopwatch_ctrl_fsm #(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int HOLD_W      = 26,
    parameter int LAP_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_btn_run,
    input  logic             i_btn_clr,
    input  logic             i_btn_lap,
    output logic             o_run_on,
    output logic             o_clr_on,
    output logic             o_lap_on,
    output logic [LAP_W-1:0] o_lap_cnt,
    output logic [1:0]       o_state
);

    typedef enum logic [1:0] {
        STOP  = 2'b00,
        RUN   = 2'b01,
        CLEAR = 2'b10,
        LAP   = 2'b11
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [LAP_W-1:0]  LAP_MAX   = '1;

    state_t              state, state_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic [LAP_W-1:0]    lap_cnt, lap_nxt;
    logic                run_prev, lap_prev;
    logic                run_rise, lap_rise;

    function automatic logic [LAP_W-1:0] lap_sat_inc(input logic [LAP_W-1:0] cnt);
        return (cnt == LAP_MAX) ? cnt : cnt + LAP_W'(1);
    endfunction

    assign run_rise = i_btn_run & ~run_prev;
    assign lap_rise = i_btn_lap & ~lap_prev;

    // Edge-detect history follows the buttons even during reset, so a button
    // held through reset release is not mistaken for a fresh press.
    always_ff @(posedge clk) begin
        run_prev <= i_btn_run;
        lap_prev <= i_btn_lap;
        if (!reset) begin
            state    <= STOP;
            hold_cnt <= '0;
            lap_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            lap_cnt  <= lap_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = '0;
        lap_nxt   = lap_cnt;
        case (state)
            STOP: begin
                if (run_rise) begin
                    state_nxt = RUN;
                end else if (i_btn_clr) begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_nxt = CLEAR;
                        lap_nxt   = '0;
                    end else begin
                        hold_nxt = hold_cnt + HOLD_W'(1);
                    end
                end
            end
            RUN: begin
                if (run_rise) begin
                    state_nxt = STOP;
                end else if (lap_rise) begin
                    state_nxt = LAP;
                    lap_nxt   = lap_sat_inc(lap_cnt);
                end
            end
            LAP: begin
                if (run_rise)      state_nxt = STOP;
                else if (lap_rise) state_nxt = RUN;
            end
            CLEAR: begin
                if (!i_btn_clr) state_nxt = STOP;
            end
        endcase
    end

    always_comb begin
        o_run_on = 1'b0;
        o_clr_on = 1'b0;
        o_lap_on = 1'b0;
        case (state)
            STOP:  ;
            RUN:   o_run_on = 1'b1;
            CLEAR: o_clr_on = 1'b1;
            LAP: begin
                o_run_on = 1'b1;
                o_lap_on = 1'b1;
            end
        endcase
    end

    assign o_state   = state;
    assign o_lap_cnt = lap_cnt;

endmodule

// File: tb/tb_stopwatch_ctrl_fsm.sv
// Self-checking bench for stopwatch_ctrl_fsm with HOLD_CYCLES=4, LAP_W=2:
// directed scenarios with constant expectations plus random traffic against a mode model.
module tb_stopwatch_ctrl_fsm;

    localparam int HOLD   = 4;
    localparam int LAPW   = 2;
    localparam int LAPSAT = (1 << LAPW) - 1;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            i_btn_run = 1'b0, i_btn_clr = 1'b0, i_btn_lap = 1'b0;
    logic            o_run_on, o_clr_on, o_lap_on;
    logic [LAPW-1:0] o_lap_cnt;
    logic [1:0]      o_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: activity flags rather than a state register.
    bit m_running, m_frozen, m_clearing, m_prun, m_plap;
    int m_hold, m_laps;

    stopwatch_ctrl_fsm #(.HOLD_CYCLES(HOLD), .HOLD_W(3), .LAP_W(LAPW)) dut (
        .clk(clk), .reset(reset),
        .i_btn_run(i_btn_run), .i_btn_clr(i_btn_clr), .i_btn_lap(i_btn_lap),
        .o_run_on(o_run_on), .o_clr_on(o_clr_on), .o_lap_on(o_lap_on),
        .o_lap_cnt(o_lap_cnt), .o_state(o_state)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] pk(input logic [1:0] st, input logic r, input logic c,
                                      input logic l, input int cnt);
        return {st, r, c, l, 2'(cnt)};
    endfunction

    function automatic logic [6:0] obs();
        return {o_state, o_run_on, o_clr_on, o_lap_on, o_lap_cnt};
    endfunction

    function automatic logic [6:0] model_vec();
        logic [1:0] st;
        st = m_clearing ? 2'd2 : (m_running ? (m_frozen ? 2'd3 : 2'd1) : 2'd0);
        return pk(st, m_running, m_clearing, m_frozen, m_laps);
    endfunction

    task automatic step(input logic rn, input logic r, input logic c, input logic l);
        bit rr, lr;
        reset = rn; i_btn_run = r; i_btn_clr = c; i_btn_lap = l;
        @(posedge clk);
        rr = r && !m_prun;
        lr = l && !m_plap;
        m_prun = r;
        m_plap = l;
        if (!rn) begin
            m_running = 0; m_frozen = 0; m_clearing = 0; m_hold = 0; m_laps = 0;
        end else if (m_clearing) begin
            if (!c) m_clearing = 0;
        end else if (m_running) begin
            if (rr) begin
                m_running = 0; m_frozen = 0;
            end else if (lr) begin
                if (!m_frozen) m_laps = (m_laps + 1 > LAPSAT) ? LAPSAT : m_laps + 1;
                m_frozen = !m_frozen;
            end
        end else begin
            if (rr) begin
                m_running = 1; m_hold = 0;
            end else if (c) begin
                m_hold++;
                if (m_hold == HOLD) begin
                    m_clearing = 1; m_laps = 0; m_hold = 0;
                end
            end else begin
                m_hold = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        n_checks++;
        if (obs() !== pk(0, 0, 0, 0, 0)) begin
            n_fail++; $display("FAIL reset_state got=%b want=%b", obs(), pk(0, 0, 0, 0, 0));
        end
        step(1, 0, 0, 0);
        n_checks++;
        if (obs() !== pk(0, 0, 0, 0, 0)) begin
            n_fail++; $display("FAIL reset_release got=%b want=%b", obs(), pk(0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_run_stop();
        step(1, 1, 0, 0);
        n_checks++;
        if (obs() !== pk(1, 1, 0, 0, 0)) begin
            n_fail++; $display("FAIL run_start got=%b want=%b", obs(), pk(1, 1, 0, 0, 0));
        end
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, 0);
            n_checks++;
            if (obs() !== pk(1, 1, 0, 0, 0)) begin
                n_fail++; $display("FAIL run_held[%0d] got=%b want=%b", i, obs(), pk(1, 1, 0, 0, 0));
            end
        end
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        n_checks++;
        if (obs() !== pk(0, 0, 0, 0, 0)) begin
            n_fail++; $display("FAIL run_stop got=%b want=%b", obs(), pk(0, 0, 0, 0, 0));
        end
        step(1, 0, 0, 0);
    endtask

    task automatic test_long_clear();
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0);
        step(1, 0, 0, 0);
        n_checks++;
        if (obs() !== pk(0, 0, 0, 0, 0)) begin
            n_fail++; $display("FAIL short_press got=%b want=%b", obs(), pk(0, 0, 0, 0, 0));
        end
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0);
        n_checks++;
        if (obs() !== pk(0, 0, 0, 0, 0)) begin
            n_fail++; $display("FAIL hold_3rd got=%b want=%b", obs(), pk(0, 0, 0, 0, 0));
        end
        step(1, 0, 1, 0);
        n_checks++;
        if (obs() !== pk(2, 0, 1, 0, 0)) begin
            n_fail++; $display("FAIL hold_4th got=%b want=%b", obs(), pk(2, 0, 1, 0, 0));
        end
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0);
        n_checks++;
        if (obs() !== pk(2, 0, 1, 0, 0)) begin
            n_fail++; $display("FAIL clear_held got=%b want=%b", obs(), pk(2, 0, 1, 0, 0));
        end
        step(1, 0, 0, 0);
        n_checks++;
        if (obs() !== pk(0, 0, 0, 0, 0)) begin
            n_fail++; $display("FAIL clear_release got=%b want=%b", obs(), pk(0, 0, 0, 0, 0));
        end
        step(1, 1, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 1, 0);
        n_checks++;
        if (obs() !== pk(1, 1, 0, 0, 0)) begin
            n_fail++; $display("FAIL clear_in_run got=%b want=%b", obs(), pk(1, 1, 0, 0, 0));
        end
        // Clear still held when stopping: the hold count starts fresh in STOP.
        step(1, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0);
        n_checks++;
        if (obs() !== pk(0, 0, 0, 0, 0)) begin
            n_fail++; $display("FAIL carry_hold_3 got=%b want=%b", obs(), pk(0, 0, 0, 0, 0));
        end
        step(1, 0, 1, 0);
        n_checks++;
        if (obs() !== pk(2, 0, 1, 0, 0)) begin
            n_fail++; $display("FAIL carry_hold_4 got=%b want=%b", obs(), pk(2, 0, 1, 0, 0));
        end
        step(1, 0, 0, 0);
    endtask

    task automatic test_lap();
        int exp_cnt [4] = '{1, 2, 3, 3};
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, 1);
            n_checks++;
            if (i % 2 == 0) begin
                if (obs() !== pk(3, 1, 0, 1, exp_cnt[i/2])) begin
                    n_fail++; $display("FAIL lap_enter[%0d] got=%b want=%b", i, obs(), pk(3, 1, 0, 1, exp_cnt[i/2]));
                end
            end else begin
                if (obs() !== pk(1, 1, 0, 0, exp_cnt[i/2])) begin
                    n_fail++; $display("FAIL lap_leave[%0d] got=%b want=%b", i, obs(), pk(1, 1, 0, 0, exp_cnt[i/2]));
                end
            end
            step(1, 0, 0, 0);
        end
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        n_checks++;
        if (obs() !== pk(0, 0, 0, 0, 3)) begin
            n_fail++; $display("FAIL lap_stop got=%b want=%b", obs(), pk(0, 0, 0, 0, 3));
        end
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0);
        n_checks++;
        if (obs() !== pk(2, 0, 1, 0, 0)) begin
            n_fail++; $display("FAIL lap_cleared got=%b want=%b", obs(), pk(2, 0, 1, 0, 0));
        end
        step(1, 0, 0, 0);
    endtask

    task automatic test_simultaneous();
        step(1, 1, 0, 0); step(1, 0, 0, 0);
        step(1, 0, 0, 1); step(1, 0, 0, 0);
        step(1, 0, 0, 1); step(1, 0, 0, 0);
        step(1, 1, 0, 1);
        n_checks++;
        if (obs() !== pk(0, 0, 0, 0, 1)) begin
            n_fail++; $display("FAIL both_in_run got=%b want=%b", obs(), pk(0, 0, 0, 0, 1));
        end
        step(1, 0, 0, 0);
        step(1, 1, 0, 0); step(1, 0, 0, 0);
        step(1, 0, 0, 1); step(1, 0, 0, 0);
        step(1, 1, 0, 1);
        n_checks++;
        if (obs() !== pk(0, 0, 0, 0, 2)) begin
            n_fail++; $display("FAIL both_in_lap got=%b want=%b", obs(), pk(0, 0, 0, 0, 2));
        end
        step(1, 0, 0, 0);
    endtask

    task automatic test_reset_behaviour();
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0);
        step(0, 0, 1, 0);
        n_checks++;
        if (obs() !== pk(0, 0, 0, 0, 0)) begin
            n_fail++; $display("FAIL reset_in_clear got=%b want=%b", obs(), pk(0, 0, 0, 0, 0));
        end
        step(1, 0, 0, 0);
        step(1, 1, 0, 0); step(1, 0, 0, 0);
        step(1, 0, 0, 1); step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        n_checks++;
        if (obs() !== pk(0, 0, 0, 0, 0)) begin
            n_fail++; $display("FAIL reset_in_lap got=%b want=%b", obs(), pk(0, 0, 0, 0, 0));
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0);
            n_checks++;
            if (obs() !== pk(0, 0, 0, 0, 0)) begin
                n_fail++; $display("FAIL run_held_thru_reset[%0d] got=%b want=%b", i, obs(), pk(0, 0, 0, 0, 0));
            end
        end
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        n_checks++;
        if (obs() !== pk(1, 1, 0, 0, 0)) begin
            n_fail++; $display("FAIL repress_after_reset got=%b want=%b", obs(), pk(1, 1, 0, 0, 0));
        end
        step(1, 0, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0);
    endtask

    task automatic test_random();
        logic r, c, l, rn;
        c = 1'b0;
        for (int i = 0; i < 800; i++) begin
            r  = ($urandom_range(0, 3) == 0);
            l  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) c = ~c;
            rn = ($urandom_range(0, 63) != 0);
            step(rn, r, c, l);
            n_checks++;
            if (obs() !== model_vec()) begin
                n_fail++; $display("FAIL random[%0d] got=%b want=%b", i, obs(), model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_run_stop();
        test_long_clear();
        test_lap();
        test_simultaneous();
        test_reset_behaviour();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
